fifo_param: RTL and testbench
=============================

Name: fifo_param

Overview:
- Parametrised synchronous single-clock FIFO; next generation of the team's 8-bit fixed FIFO.
- Generalised in data width and depth.
- Adds occupancy count, programmable almost-full/almost-empty thresholds, and overflow/underflow error pulses.
- Sits between producer and consumer datapaths in the same clock domain; drop-in for the old FIFO when WIDTH=8.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=2.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.
- Derived localparam AW = $clog2(DEPTH); count is AW+1 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; active-high, synchronous to clk
- wr_en  input  1  write request
- rd_en  input  1  read request
- data_in  input  WIDTH  write data, sampled on an accepted write
- data_out  output  WIDTH  read data
- empt  output  1  FIFO empty
- full  output  1  FIFO full
- almost_empty  output  1  count <= AE_LEVEL
- almost_full  output  1  count >= AF_LEVEL
- count  output  AW+1  current occupancy, 0..DEPTH
- overflow  output  1  one-cycle pulse: write rejected
- underflow  output  1  one-cycle pulse: read rejected

Behaviour:
- Reset (rst=1 at a clk edge):
  - rd_ptr=0, wr_ptr=0, count=0, data_out=0.
  - empt=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0).
  - overflow=0, underflow=0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored data; the next cycle behaves as freshly reset.
- Accepts:
  - Write accepted = wr_en & ~full. Data stored at wr_ptr; wr_ptr increments modulo DEPTH.
  - Read accepted = rd_en & ~empt. rd_ptr increments modulo DEPTH.
- Simultaneous wr_en and rd_en:
  - When full: both accepted (read frees the slot in the same cycle); count unchanged; full stays 1.
  - When empty: write accepted, read rejected; underflow pulses; count becomes 1.
  - Otherwise: both accepted; count unchanged.
- Flags:
  - Pointer wrap: DEPTH-1 -> 0; no bubble.
  - count, empt, full, almost_* are registered and updated on the edge that accepts the operation (valid the following cycle).
  - empt = (count==0); full = (count==DEPTH).
- Error pulses:
  - overflow = 1 for exactly one cycle after a clk edge where wr_en & full and no simultaneous accepted read. State is unchanged.
  - underflow = 1 for exactly one cycle after a clk edge where a read is rejected. State is unchanged; data_out holds.
- Read latency (standard mode): data_out is registered and loads mem[rd_ptr] on the edge accepting the read, i.e. valid one cycle after rd_en. It holds its value when no read is accepted.
- Width rules: all comparisons unsigned. count never exceeds DEPTH or goes below 0.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - data_out continuously presents mem[rd_ptr] whenever empt=0, so zero read latency.
  - rd_en acts as a pop acknowledge.
  - data_out is don't-care (drives last head value) when empt=1.
  - A word written into an empty FIFO appears on data_out the cycle after the write edge, together with empt deasserting.
  - Flags, count and error pulses are identical to standard mode.
- Undefined: standard registered-read behaviour above.

Test Plan:
1. Release rst, write 4,5,6 (WIDTH=8, DEPTH=4) -> count 1,2,3; empt 0 after first write; full 0. Read 3 -> data_out 4,5,6, each one cycle after its rd_en; empt=1; count=0.
2. DEPTH=4: write 8'hA0..A3 -> full=1, almost_full=1 (AF_LEVEL=2 reached at count 2). 5th write 8'hA4 -> overflow pulses one cycle; count stays 4. Read all -> A0..A3; A4 never appears.
3. Empty FIFO, rd_en=1 -> underflow one cycle; data_out unchanged; count 0. Then wr_en and rd_en together with data_in=8'h33 -> underflow pulses; count=1; next read returns 8'h33.
4. Full FIFO (4 entries), wr_en and rd_en together with data_in=8'h77 -> oldest word read out; count stays 4; full stays 1; 8'h77 is read out last.
5. Wrap-around: 10 cycles of interleaved single write/read with values 1..10 -> outputs 1..10 in order; pointers wrap twice; empt toggles correctly.
6. Write 3 words, assert rst for one cycle -> count=0, empt=1, data_out=0, no error pulse. Then write 8'h5A and read -> 8'h5A. Repeat with FIFO_FWFT_EN defined -> 8'h5A is on data_out the cycle after the write, before rd_en.

Source files
------------

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds and overflow/underflow pulses. Define FIFO_FWFT_EN for first-word-fall-through reads.
module fifo_param #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       empt,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_empt;
  logic             r_full;
  logic             r_almost_empty;
  logic             r_almost_full;
  logic             r_overflow;
  logic             r_underflow;
  logic [WIDTH-1:0] r_dout;

  logic             w_rd_acc;
  logic             w_wr_acc;
  logic [AW:0]      w_count_nxt;

  // A read on a full FIFO frees the slot the simultaneous write lands in.
  assign w_rd_acc    = rd_en & ~r_empt;
  assign w_wr_acc    = wr_en & (~r_full | w_rd_acc);
  assign w_count_nxt = r_count + (AW+1)'(w_wr_acc) - (AW+1)'(w_rd_acc);

  always_ff @(posedge clk) begin
    if (w_wr_acc && !rst) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_empt         <= 1'b1;
      r_full         <= 1'b0;
      r_almost_empty <= 1'b1;
      r_almost_full  <= (AF_LEVEL == 0);
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count        <= w_count_nxt;
      r_empt         <= (w_count_nxt == '0);
      r_full         <= (32'(w_count_nxt) == DEPTH);
      r_almost_empty <= (32'(w_count_nxt) <= AE_LEVEL);
      r_almost_full  <= (32'(w_count_nxt) >= AF_LEVEL);
      r_overflow     <= wr_en & r_full & ~w_rd_acc;
      r_underflow    <= rd_en & r_empt;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is shown combinationally; r_dout keeps the last head for the empty case.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout <= '0;
    end else if (!r_empt) begin
      r_dout <= r_mem[r_rd_ptr];
    end
  end

  assign data_out = r_empt ? r_dout : r_mem[r_rd_ptr];
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout <= '0;
    end else if (w_rd_acc) begin
      r_dout <= r_mem[r_rd_ptr];
    end
  end

  assign data_out = r_dout;
`endif

  assign empt         = r_empt;
  assign full         = r_full;
  assign almost_empty = r_almost_empty;
  assign almost_full  = r_almost_full;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param (WIDTH=8, DEPTH=4): directed steps then random traffic,
// every cycle compared against a queue-based reference model.
module tb_fifo_param;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AFL   = DEPTH - 2;
  localparam int unsigned AEL   = 2;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       empt;
  logic       full;
  logic       almost_empty;
  logic       almost_full;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic       m_over;
  logic       m_under;

  fifo_param #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
    .data_out(data_out), .empt(empt), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] d);
    int n;
    logic rd_ok;
    logic wr_ok;
    logic [7:0] popped;
    rst = r; wr_en = w; rd_en = rd; data_in = d;
    @(posedge clk);
    n = q.size();
    popped = 8'h00;
    if (r) begin
      q.delete();
      m_dout = 8'h00; m_over = 1'b0; m_under = 1'b0;
    end else begin
      rd_ok   = rd && (n > 0);
      wr_ok   = w && ((n < int'(DEPTH)) || rd_ok);
      m_under = rd && (n == 0);
      m_over  = w && (n == int'(DEPTH)) && !rd_ok;
      if (rd_ok) popped = q.pop_front();
      if (wr_ok) q.push_back(d);
`ifdef FIFO_FWFT_EN
      if (q.size() > 0) m_dout = q[0];
      else if (rd_ok)   m_dout = popped;
`else
      if (rd_ok) m_dout = popped;
`endif
    end
    #1;
    n = q.size();
    chk("count",        32'(count),        n);
    chk("empt",         32'(empt),         32'(n == 0));
    chk("full",         32'(full),         32'(n == int'(DEPTH)));
    chk("almost_empty", 32'(almost_empty), 32'(n <= int'(AEL)));
    chk("almost_full",  32'(almost_full),  32'(n >= int'(AFL)));
    chk("overflow",     32'(overflow),     32'(m_over));
    chk("underflow",    32'(underflow),    32'(m_under));
    chk("data_out",     32'(data_out),     32'(m_dout));
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;
    m_dout = 8'h00; m_over = 1'b0; m_under = 1'b0;
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);

    // basic write/read
    for (int i = 4; i <= 6; i++) step(0, 1, 0, 8'(i));
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h00);

    // fill, overflow, drain
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'hA0 + 8'(i));
    step(0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'h00);

    // underflow, write+read on empty
    step(0, 0, 1, 8'h00);
    step(0, 1, 1, 8'h33);
    step(0, 0, 1, 8'h00);

    // write+read on full
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h10 + 8'(i));
    step(0, 1, 1, 8'h77);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00);

    // wrap-around
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, 0, 8'(i));
      step(0, 0, 1, 8'h00);
    end

    // reset mid-operation
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'hC0 + 8'(i));
    step(1, 0, 0, 8'h00);
    step(0, 1, 0, 8'h5A);
    step(0, 0, 0, 8'h00);
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 99) < 55),
           ($urandom_range(0, 99) < 50), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
